vic_wb: RTL and testbench

VIC_WB -- requirements
Module: vic_wb

---
 rtl/vic_pkg.sv | 19 +
 rtl/vic_prio.sv | 42 ++++
 rtl/vic_wb.sv | 150 +++++++++++++++
 tb/tb_vic_wb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vic_pkg.sv
// Shared definitions for the vectored interrupt controller: handshake state
// encoding, parameter defaults and the vector width.
package vic_pkg;

  localparam int VEC_W = 16;
  localparam int NSRC_DEF = 8;
  localparam logic [VEC_W-1:0] SPURIOUS_VEC_DEF = 16'o000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_DROP = 2'd2
  } vic_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vic_prio.sv
// Combinational arbiter: first set request found when scanning upward from
// 'start', wrapping modulo NSRC.
module vic_prio
  import vic_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  localparam int IDX_W = idx_width(NSRC)
) (
  input  logic [NSRC-1:0]  req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  int unsigned      cand_s;
  logic [IDX_W-1:0] cand_idx_s;

  // wrap-around scan, first hit wins
  always_comb begin
    winner     = '0;
    valid      = 1'b0;
    cand_s     = 32'd0;
    cand_idx_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      cand_s = 32'(start) + 32'(i);
      if (cand_s >= 32'(NSRC)) begin
        cand_s = cand_s - 32'(NSRC);
      end else begin
        cand_s = cand_s;
      end
      cand_idx_s = IDX_W'(cand_s);
      if (!valid && req[cand_idx_s]) begin
        winner = cand_idx_s;
        valid  = 1'b1;
      end else begin
        winner = winner;
        valid  = valid;
      end
    end
  end

endmodule

// File: rtl/vic_wb.sv
// Vectored interrupt controller with istb/iack vector handshake.
// Define VIC_ROUNDROBIN_EN for round-robin arbitration (default: fixed priority).
module vic_wb
  import vic_pkg::*;
#(
  parameter int                    NSRC         = NSRC_DEF,
  parameter logic [NSRC*VEC_W-1:0] VEC_TABLE    = {NSRC{16'o000060}},
  parameter logic [VEC_W-1:0]      SPURIOUS_VEC = SPURIOUS_VEC_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             init_i,
  input  logic [NSRC-1:0]  irq_i,
  output logic             virq_o,
  input  logic             istb_i,
  output logic [VEC_W-1:0] ivec_o,
  output logic             iack_o,
  output logic [NSRC-1:0]  ack_o
);

  localparam int IDX_W = idx_width(NSRC);

  vic_state_e       state_r, state_nxt_s;
  logic             virq_r, virq_nxt_s;
  logic             iack_r, iack_nxt_s;
  logic [VEC_W-1:0] ivec_r, ivec_nxt_s;
  logic [NSRC-1:0]  ack_r, ack_nxt_s;
  logic [IDX_W-1:0] win_r, win_nxt_s;
  logic             win_vld_r, win_vld_nxt_s;
  logic [IDX_W-1:0] start_s, prio_win_s;
  logic             prio_vld_s;

  function automatic logic [VEC_W-1:0] vec_of(input logic [IDX_W-1:0] w, input logic v);
    if (v) begin
      return VEC_TABLE[32'(w)*VEC_W +: VEC_W];
    end else begin
      return SPURIOUS_VEC;
    end
  endfunction

  vic_prio #(.NSRC(NSRC)) u_prio (
    .req    (irq_i),
    .start  (start_s),
    .winner (prio_win_s),
    .valid  (prio_vld_s)
  );

`ifdef VIC_ROUNDROBIN_EN
  logic [IDX_W-1:0] ptr_r, ptr_nxt_s;

  assign start_s = ptr_r;

  // pointer advances past the winner only on a real grant
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (state_r == ST_IDLE && istb_i && !init_i && prio_vld_s) begin
      ptr_nxt_s = (prio_win_s == IDX_W'(NSRC-1)) ? '0 : prio_win_s + IDX_W'(1);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // round-robin pointer register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end
`else
  assign start_s = '0;
`endif

  // next state and next registered outputs
  always_comb begin
    state_nxt_s   = state_r;
    virq_nxt_s    = 1'b0;
    iack_nxt_s    = iack_r;
    ivec_nxt_s    = ivec_r;
    ack_nxt_s     = '0;
    win_nxt_s     = win_r;
    win_vld_nxt_s = win_vld_r;
    if (init_i) begin
      state_nxt_s = ST_IDLE;
      iack_nxt_s  = 1'b0;
      ivec_nxt_s  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (istb_i) begin
            state_nxt_s   = ST_ACK;
            win_nxt_s     = prio_win_s;
            win_vld_nxt_s = prio_vld_s;
            iack_nxt_s    = 1'b1;
            ivec_nxt_s    = vec_of(prio_win_s, prio_vld_s);
            ack_nxt_s     = prio_vld_s ? (NSRC'(1'b1) << prio_win_s) : '0;
          end else begin
            virq_nxt_s = |irq_i;
          end
        end
        ST_ACK: begin
          state_nxt_s = ST_DROP;
          ivec_nxt_s  = vec_of(win_r, win_vld_r);
        end
        ST_DROP: begin
          if (!istb_i) begin
            state_nxt_s = ST_IDLE;
            iack_nxt_s  = 1'b0;
            ivec_nxt_s  = '0;
          end else begin
            ivec_nxt_s = vec_of(win_r, win_vld_r);
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          iack_nxt_s  = 1'b0;
          ivec_nxt_s  = '0;
        end
      endcase
    end
  end

  // state, latched winner and output registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_r   <= ST_IDLE;
      virq_r    <= 1'b0;
      iack_r    <= 1'b0;
      ivec_r    <= '0;
      ack_r     <= '0;
      win_r     <= '0;
      win_vld_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      virq_r    <= virq_nxt_s;
      iack_r    <= iack_nxt_s;
      ivec_r    <= ivec_nxt_s;
      ack_r     <= ack_nxt_s;
      win_r     <= win_nxt_s;
      win_vld_r <= win_vld_nxt_s;
    end
  end

  assign virq_o = virq_r;
  assign iack_o = iack_r;
  assign ivec_o = ivec_r;
  assign ack_o  = ack_r;

endmodule

// File: tb/tb_vic_wb.sv
// Self-checking bench for vic_wb: directed handshake scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_vic_wb;

  localparam int N = 8;
  localparam logic [N*16-1:0] TB_VEC = {16'o000134, 16'o000130, 16'o000124, 16'o000120,
                                        16'o000114, 16'o000110, 16'o000104, 16'o000100};

  logic         clk_p = 1'b0;
  logic         rst_n = 1'b1;
  logic         init = 1'b0;
  logic         istb = 1'b0;
  logic [N-1:0] irq = '0;
  logic         virq, iack;
  logic [15:0]  ivec;
  logic [N-1:0] ack;

  always #5 clk_p = ~clk_p;

  vic_wb #(.NSRC(N), .VEC_TABLE(TB_VEC), .SPURIOUS_VEC(16'o000000)) dut (
    .wb_clk_i (clk_p),
    .wb_rst_n (rst_n),
    .init_i   (init),
    .irq_i    (irq),
    .virq_o   (virq),
    .istb_i   (istb),
    .ivec_o   (ivec),
    .iack_o   (iack),
    .ack_o    (ack)
  );

  // reference model: phase 0 = waiting, 1 = first vector cycle, 2 = holding vector
  int           m_phase;
  int           m_ptr;
  bit           m_rr;
  logic         m_virq, m_iack;
  logic [15:0]  m_ivec;
  logic [N-1:0] m_ack;
  int           n_pass = 0;
  int           n_total = 0;

  function automatic int pick(input logic [N-1:0] r, input int start);
    int idx;
    for (int i = 0; i < N; i++) begin
      idx = (start + i) % N;
      if (((r >> idx) & 8'd1) != 8'd0) return idx;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".virq"}, {31'd0, virq}, {31'd0, m_virq});
    check({tag, ".iack"}, {31'd0, iack}, {31'd0, m_iack});
    check({tag, ".ivec"}, {16'd0, ivec}, {16'd0, m_ivec});
    check({tag, ".ack"},  {24'd0, ack},  {24'd0, m_ack});
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0;
    m_virq = 1'b0; m_iack = 1'b0; m_ivec = 16'd0; m_ack = '0;
  endtask

  // applies the sampled inputs of the coming clock edge to the model
  task automatic model_edge();
    int w;
    m_ack = '0;
    if (init) begin
      m_phase = 0; m_virq = 1'b0; m_iack = 1'b0; m_ivec = 16'd0;
    end else if (m_phase == 0) begin
      if (istb) begin
        w = pick(irq, m_ptr);
        m_phase = 1; m_virq = 1'b0; m_iack = 1'b1;
        if (w >= 0) begin
          m_ivec = 16'(64 + 4 * w);
          m_ack = N'(1) << w;
          if (m_rr) m_ptr = (w + 1) % N;
        end else begin
          m_ivec = 16'd0;
        end
      end else begin
        m_virq = (irq != '0);
      end
    end else if (m_phase == 1) begin
      m_phase = 2; m_virq = 1'b0;
    end else begin
      m_virq = 1'b0;
      if (!istb) begin
        m_phase = 0; m_iack = 1'b0; m_ivec = 16'd0;
      end
    end
  endtask

  task automatic sync();
    @(posedge clk_p);
    #1;
  endtask

  task automatic step(input logic [N-1:0] r, input logic s, input logic ini, input string tag);
    irq = r; istb = s; init = ini;
    model_edge();
    sync();
    check_all(tag);
  endtask

  initial begin
    logic [N-1:0] r;
    logic         s;
`ifdef VIC_ROUNDROBIN_EN
    m_rr = 1'b1;
`else
    m_rr = 1'b0;
`endif
    model_reset();

    // asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check_all("reset");
    sync(); sync();
    rst_n = 1'b1;

    // single source, 3-cycle istb
    step(8'b0000_0100, 1'b0, 1'b0, "r29_req");
    check("r29_virq", {31'd0, virq}, 32'd1);
    step(8'b0000_0100, 1'b1, 1'b0, "r29_ack");
    check("r29_ivec", {16'd0, ivec}, 32'o000110);
    check("r29_ackbit", {24'd0, ack}, 32'h04);
    step(8'b0000_0100, 1'b1, 1'b0, "r29_drop1");
    check("r29_ackoff", {24'd0, ack}, 32'h00);
    step(8'b0000_0100, 1'b1, 1'b0, "r29_drop2");
    check("r29_iack3", {31'd0, iack}, 32'd1);
    step(8'b0000_0100, 1'b0, 1'b0, "r29_idle");
    check("r29_iack_clr", {31'd0, iack}, 32'd0);
    check("r20_virq_gap", {31'd0, virq}, 32'd0);
    step(8'b0000_0100, 1'b0, 1'b0, "r20_virq_back");

    // two sources pending
    step(8'b1000_0010, 1'b1, 1'b0, "r30_ack");
`ifndef VIC_ROUNDROBIN_EN
    check("r30_winner", {24'd0, ack}, 32'h02);
`endif
    step(8'b1000_0010, 1'b0, 1'b0, "r30_drop");
    step(8'b1000_0010, 1'b0, 1'b0, "r30_idle");
    step(8'b1000_0010, 1'b1, 1'b0, "r30_ack2");
    step(8'b1000_0010, 1'b0, 1'b0, "r30_drop2");
    step(8'b1000_0010, 1'b0, 1'b0, "r30_idle2");

    // request vanishes before istb
    step(8'b0000_0100, 1'b0, 1'b0, "r31_req");
    step(8'b0000_0000, 1'b1, 1'b0, "r31_spur");
    check("r31_iack", {31'd0, iack}, 32'd1);
    check("r31_ivec", {16'd0, ivec}, 32'd0);
    check("r31_ack", {24'd0, ack}, 32'd0);
    step(8'b0000_0000, 1'b0, 1'b0, "r31_drop");
    step(8'b0000_0000, 1'b0, 1'b0, "r31_idle");

    // init while holding the vector
    step(8'b0000_0001, 1'b1, 1'b0, "r32_ack");
    step(8'b0000_0001, 1'b1, 1'b0, "r32_drop");
    step(8'b0000_0001, 1'b1, 1'b1, "r32_init");
    check("r32_iack", {31'd0, iack}, 32'd0);
    check("r32_virq", {31'd0, virq}, 32'd0);
    step(8'b0000_0001, 1'b0, 1'b0, "r32_idle");
    check("r32_virq_idle", {31'd0, virq}, 32'd1);

    // reset mid-ACK, then release with a request pending
    step(8'b0000_0001, 1'b1, 1'b0, "r33_ack");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("r33_async");
    @(negedge clk_p);
    rst_n = 1'b1; irq = 8'b0000_0001; istb = 1'b0; init = 1'b0;
    model_edge();
    sync();
    check("r33_virq", {31'd0, virq}, 32'd1);
    check_all("r33_release");

    // randomized traffic
    s = 1'b0;
    for (int k = 0; k < 400; k++) begin
      r = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      if (s) s = ($urandom_range(0, 9) < 7);
      else   s = ($urandom_range(0, 3) == 0);
      step(r, s, ($urandom_range(0, 19) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
